// File: rtl/conv_seq_ctrl_if.sv
// Bundle of the sequencer's job handshake, SRAM read/write ports and the
// Conv datapath strobes. The sequencer uses the master side.
interface conv_seq_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int RES_BITS  = 2 * DATA_BITS + 2
);
  logic                 start;
  logic [ADDR_BITS-1:0] len;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_rdata;
  logic [ADDR_BITS-1:0] if_addr;
  logic [DATA_BITS-1:0] if_rdata;
  logic                 conv_clear;
  logic                 conv_w_w;
  logic [DATA_BITS-1:0] conv_w_in;
  logic                 conv_if_w;
  logic [DATA_BITS-1:0] conv_if_in;
  logic [RES_BITS-1:0]  conv_result;
  logic                 out_we;
  logic [ADDR_BITS-1:0] out_addr;
  logic [RES_BITS-1:0]  out_wdata;

  modport master (
    input  start, len, w_rdata, if_rdata, conv_result,
    output busy, done, w_addr, if_addr, conv_clear, conv_w_w, conv_w_in,
           conv_if_w, conv_if_in, out_we, out_addr, out_wdata
  );

  modport slave (
    output start, len, w_rdata, if_rdata, conv_result,
    input  busy, done, w_addr, if_addr, conv_clear, conv_w_w, conv_w_in,
           conv_if_w, conv_if_in, out_we, out_addr, out_wdata
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Conv sequencer: on start, clears Conv, shifts in 3 weights, streams len
// features and writes one Conv result per full 3-sample window.
// All strobes/addresses are registered from the next-state values so they
// line up with the cycle of the state they belong to; the data buses are
// passed straight through from the memories / Conv in the strobed cycle.
module conv_seq_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10,
  parameter int RES_BITS  = 2 * DATA_BITS + 2
) (
  input logic             clk,
  input logic             rst,
  conv_seq_ctrl_if.master bus
);

  // One spare bit so the feature counter can reach len without wrapping.
  localparam int CW = ADDR_BITS + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_W = 3'd2,
    LOAD_F = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t               state_r, state_nxt;
  logic [CW-1:0]        cnt_r, cnt_nxt;
  logic [ADDR_BITS-1:0] len_r, len_nxt;
  logic [CW-1:0]        len_ext;

  logic                 clear_r, clear_nxt;
  logic                 ww_r, ww_nxt;
  logic                 ifw_r, ifw_nxt;
  logic                 we_r, we_nxt;
  logic                 done_r, done_nxt;
  logic                 busy_r, busy_nxt;
  logic [ADDR_BITS-1:0] w_addr_r, w_addr_nxt;
  logic [ADDR_BITS-1:0] if_addr_r, if_addr_nxt;
  logic [ADDR_BITS-1:0] out_addr_r, out_addr_nxt;

  assign len_ext = {1'b0, len_nxt};

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      len_r      <= '0;
      clear_r    <= 1'b0;
      ww_r       <= 1'b0;
      ifw_r      <= 1'b0;
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      w_addr_r   <= '0;
      if_addr_r  <= '0;
      out_addr_r <= '0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      len_r      <= len_nxt;
      clear_r    <= clear_nxt;
      ww_r       <= ww_nxt;
      ifw_r      <= ifw_nxt;
      we_r       <= we_nxt;
      done_r     <= done_nxt;
      busy_r     <= busy_nxt;
      w_addr_r   <= w_addr_nxt;
      if_addr_r  <= if_addr_nxt;
      out_addr_r <= out_addr_nxt;
    end
  end

  // Next-state and counter progression; start/len only matter in IDLE.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    len_nxt   = len_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          len_nxt = bus.len;
          cnt_nxt = '0;
          if (bus.len < ADDR_BITS'(2'd3)) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = CLEAR;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        state_nxt = LOAD_W;
        cnt_nxt   = '0;
      end
      LOAD_W: begin
        if (cnt_r == CW'(2'd2)) begin
          state_nxt = LOAD_F;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + CW'(1'b1);
        end
      end
      // Runs len+1 cycles: the extra one captures the last window result.
      LOAD_F: begin
        if (cnt_r == {1'b0, len_r}) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt_r + CW'(1'b1);
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    clear_nxt    = 1'b0;
    ww_nxt       = 1'b0;
    ifw_nxt      = 1'b0;
    we_nxt       = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = 1'b0;
    w_addr_nxt   = w_addr_r;
    if_addr_nxt  = if_addr_r;
    out_addr_nxt = out_addr_r;
    case (state_nxt)
      IDLE: begin
        busy_nxt = 1'b0;
      end
      CLEAR: begin
        clear_nxt  = 1'b1;
        busy_nxt   = 1'b1;
        w_addr_nxt = '0;
      end
      // Weight i is pushed while weight i+1 is being read; the last
      // weight cycle also issues the first feature read.
      LOAD_W: begin
        ww_nxt   = 1'b1;
        busy_nxt = 1'b1;
        if (cnt_nxt < CW'(2'd2)) begin
          w_addr_nxt = ADDR_BITS'(cnt_nxt + CW'(1'b1));
        end else begin
          if_addr_nxt = '0;
        end
      end
      // Feature i is pushed at count i; its window result (i>=2) is
      // written one cycle later, at count i+1.
      LOAD_F: begin
        busy_nxt = 1'b1;
        if (cnt_nxt < len_ext) begin
          ifw_nxt = 1'b1;
        end else begin
          ifw_nxt = 1'b0;
        end
        if ((cnt_nxt + CW'(1'b1)) < len_ext) begin
          if_addr_nxt = ADDR_BITS'(cnt_nxt + CW'(1'b1));
        end else begin
          if_addr_nxt = if_addr_r;
        end
        if (cnt_nxt >= CW'(2'd3)) begin
          we_nxt       = 1'b1;
          out_addr_nxt = ADDR_BITS'(cnt_nxt - CW'(2'd3));
        end else begin
          we_nxt = 1'b0;
        end
      end
      FINISH: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.w_addr     = w_addr_r;
  assign bus.if_addr    = if_addr_r;
  assign bus.conv_clear = clear_r;
  assign bus.conv_w_w   = ww_r;
  assign bus.conv_if_w  = ifw_r;
  assign bus.out_we     = we_r;
  assign bus.out_addr   = out_addr_r;
  assign bus.conv_w_in  = ww_r ? bus.w_rdata : {DATA_BITS{1'b0}};
  assign bus.conv_if_in = ifw_r ? bus.if_rdata : {DATA_BITS{1'b0}};
  assign bus.out_wdata  = we_r ? bus.conv_result : {RES_BITS{1'b0}};

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Testbench for conv_seq_ctrl: models the three SRAMs and the Conv stage,
// logs every strobe with its cycle number relative to the accepted start,
// and compares against window sums computed directly from memory contents.
module tb_conv_seq_ctrl;

  localparam int DB = 8;
  localparam int AB = 10;
  localparam int RB = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_seq_ctrl_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .RES_BITS(RB)) bus ();

  conv_seq_ctrl #(.DATA_BITS(DB), .ADDR_BITS(AB), .RES_BITS(RB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int tick     = 0;
  int t0       = 0;

  logic [DB-1:0] wmem [0:1023];
  logic [DB-1:0] fmem [0:1023];
  logic [DB-1:0] cw [0:2];
  logic [DB-1:0] cf [0:2];
  int            conv_sum;

  int            wr_cyc [$];
  int            wr_addr [$];
  logic [RB-1:0] wr_data [$];
  int            done_cyc [$];
  int            busy_cyc [$];
  int            clear_cyc [$];
  int            n_ww, n_ifw;

  logic [69:0] all_out;
  assign all_out = {bus.busy, bus.done, bus.w_addr, bus.if_addr, bus.conv_clear,
                    bus.conv_w_w, bus.conv_w_in, bus.conv_if_w, bus.conv_if_in,
                    bus.out_we, bus.out_addr, bus.out_wdata};

  // Fixed patterns: weights, features, len and hand-computed results.
  int            pw   [2][3] = '{'{1, 2, 3}, '{-1, 0, 1}};
  int            pf   [2][5] = '{'{1, 2, 3, 4, 5}, '{10, -20, 30, -40, 0}};
  int            plen [2]    = '{5, 4};
  logic [RB-1:0] pexp [2][3] = '{'{18'd14, 18'd20, 18'd26}, '{18'd20, 18'h3FFEC, 18'd0}};

  // Edge counter used to number cycles relative to the accepted start.
  always @(posedge clk) tick <= tick + 1;

  // Synchronous-read SRAM models.
  always @(posedge clk) begin
    bus.w_rdata  <= wmem[bus.w_addr];
    bus.if_rdata <= fmem[bus.if_addr];
  end

  // Conv stage model: two 3-deep shift registers, oldest entry at index 0.
  always @(posedge clk) begin
    if (rst || bus.conv_clear) begin
      for (int i = 0; i < 3; i++) begin
        cw[i] <= '0;
        cf[i] <= '0;
      end
    end else begin
      if (bus.conv_w_w) begin
        cw[0] <= cw[1]; cw[1] <= cw[2]; cw[2] <= bus.conv_w_in;
      end
      if (bus.conv_if_w) begin
        cf[0] <= cf[1]; cf[1] <= cf[2]; cf[2] <= bus.conv_if_in;
      end
    end
  end
  assign conv_sum = int'($signed(cw[0])) * int'($signed(cf[0]))
                  + int'($signed(cw[1])) * int'($signed(cf[1]))
                  + int'($signed(cw[2])) * int'($signed(cf[2]));
  assign bus.conv_result = conv_sum[RB-1:0];

  // Activity log, sampled mid-cycle; cycle 1 is the one after the start edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_we) begin
        wr_cyc.push_back(tick - t0 + 1);
        wr_addr.push_back(int'(bus.out_addr));
        wr_data.push_back(bus.out_wdata);
      end
      if (bus.done)       done_cyc.push_back(tick - t0 + 1);
      if (bus.busy)       busy_cyc.push_back(tick - t0 + 1);
      if (bus.conv_clear) clear_cyc.push_back(tick - t0 + 1);
      if (bus.conv_w_w)   n_ww <= n_ww + 1;
      if (bus.conv_if_w)  n_ifw <= n_ifw + 1;
    end
  end

  // Expected window k result taken straight from memory contents.
  function automatic logic [RB-1:0] ref_win(input int k);
    int s;
    s = int'($signed(wmem[0])) * int'($signed(fmem[k]))
      + int'($signed(wmem[1])) * int'($signed(fmem[k+1]))
      + int'($signed(wmem[2])) * int'($signed(fmem[k+2]));
    return RB'(s);
  endfunction

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    done_cyc.delete(); busy_cyc.delete(); clear_cyc.delete();
    n_ww = 0; n_ifw = 0;
  endtask

  task automatic randomize_mem(input int n);
    for (int i = 0; i < 3; i++) wmem[i] = DB'($urandom);
    for (int i = 0; i < n; i++) fmem[i] = DB'($urandom);
  endtask

  // Pulse start for one edge; that edge becomes cycle 0. Returns in cycle 1.
  task automatic start_job(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = AB'(l);
    @(posedge clk);
    #1 t0 = tick;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = AB'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cyc.size() == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_assert++;
    if (done_cyc.size() == 0) begin
      n_fail++;
      $display("FAIL wait_done: no done pulse seen within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (all_out !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (all_out !== 70'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, expected 0", all_out);
    end
  endtask

  task automatic test_patterns();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 3; i++) wmem[i] = DB'(pw[t][i]);
      for (int i = 0; i < 5; i++) fmem[i] = DB'(pf[t][i]);
      clear_logs();
      start_job(plen[t]);
      wait_done(60);
      repeat (3) @(posedge clk);
      n_assert++;
      if (wr_cyc.size() != plen[t] - 2) begin
        n_fail++;
        $display("FAIL pat%0d write_count: got %0d, expected %0d", t, wr_cyc.size(), plen[t] - 2);
      end
      for (int k = 0; k < wr_cyc.size() && k < plen[t] - 2; k++) begin
        n_assert++;
        if (wr_cyc[k] !== 8 + k || wr_addr[k] !== k || wr_data[k] !== pexp[t][k]) begin
          n_fail++;
          $display("FAIL pat%0d write%0d: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                   t, k, wr_cyc[k], wr_addr[k], wr_data[k], 8 + k, k, pexp[t][k]);
        end
      end
      n_assert++;
      if (done_cyc.size() != 1 || done_cyc[0] != plen[t] + 6) begin
        n_fail++;
        $display("FAIL pat%0d done: got %0d pulses first at %0d, expected 1 at %0d",
                 t, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, plen[t] + 6);
      end
      n_assert++;
      if (busy_cyc.size() != plen[t] + 5 || busy_cyc[0] != 1 || busy_cyc[busy_cyc.size()-1] != plen[t] + 5) begin
        n_fail++;
        $display("FAIL pat%0d busy: got %0d cycles, expected cycles 1..%0d", t, busy_cyc.size(), plen[t] + 5);
      end
      n_assert++;
      if (clear_cyc.size() != 1 || clear_cyc[0] != 1 || n_ww != 3 || n_ifw != plen[t]) begin
        n_fail++;
        $display("FAIL pat%0d strobes: got clear %0d ww %0d ifw %0d, expected clear 1@1 ww 3 ifw %0d",
                 t, clear_cyc.size(), n_ww, n_ifw, plen[t]);
      end
    end
  endtask

  task automatic test_short_len();
    int lens [3] = '{2, 0, 1};
    for (int t = 0; t < 3; t++) begin
      clear_logs();
      start_job(lens[t]);
      wait_done(10);
      repeat (3) @(posedge clk);
      n_assert++;
      if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
        n_fail++;
        $display("FAIL short len%0d done: got %0d pulses, expected 1 at cycle 1", lens[t], done_cyc.size());
      end
      n_assert++;
      if (busy_cyc.size() != 0 || clear_cyc.size() != 0 || n_ww != 0 || n_ifw != 0 || wr_cyc.size() != 0) begin
        n_fail++;
        $display("FAIL short len%0d activity: got busy %0d clear %0d ww %0d ifw %0d writes %0d, expected all 0",
                 lens[t], busy_cyc.size(), clear_cyc.size(), n_ww, n_ifw, wr_cyc.size());
      end
    end
  endtask

  task automatic test_ignore_start();
    randomize_mem(5);
    clear_logs();
    start_job(5);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.len = AB'(3);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.len = AB'(9);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(60);
    repeat (20) @(posedge clk);
    n_assert++;
    if (wr_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL ignore write_count: got %0d, expected 3", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < 3; k++) begin
      n_assert++;
      if (wr_cyc[k] !== 8 + k || wr_addr[k] !== k || wr_data[k] !== ref_win(k)) begin
        n_fail++;
        $display("FAIL ignore write%0d: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                 k, wr_cyc[k], wr_addr[k], wr_data[k], 8 + k, k, ref_win(k));
      end
    end
    n_assert++;
    if (done_cyc.size() != 1 || done_cyc[0] != 11 || clear_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL ignore done: got %0d done pulses and %0d clears, expected 1 done at 11 and 1 clear",
               done_cyc.size(), clear_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    randomize_mem(8);
    clear_logs();
    start_job(8);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_assert++;
    if (all_out !== 70'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h, expected 0", all_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    n_assert++;
    if (wr_cyc.size() != 0 || done_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_activity: got %0d writes %0d done, expected 0 and 0", wr_cyc.size(), done_cyc.size());
    end
    randomize_mem(3);
    clear_logs();
    start_job(3);
    wait_done(30);
    repeat (3) @(posedge clk);
    n_assert++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != 8 || wr_addr[0] != 0 || wr_data[0] !== ref_win(0)) begin
      n_fail++;
      $display("FAIL after_reset write: got %0d writes, expected 1 at cycle 8 addr 0 data %h",
               wr_cyc.size(), ref_win(0));
    end
    n_assert++;
    if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
      n_fail++;
      $display("FAIL after_reset done: got %0d pulses, expected 1 at cycle 9", done_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int lens [2] = '{3, 6};
    for (int t = 0; t < 2; t++) begin
      randomize_mem(lens[t]);
      clear_logs();
      start_job(lens[t]);
      wait_done(60);
      if (t == 1) repeat (3) @(posedge clk);
      n_assert++;
      if (wr_cyc.size() != lens[t] - 2) begin
        n_fail++;
        $display("FAIL b2b job%0d write_count: got %0d, expected %0d", t, wr_cyc.size(), lens[t] - 2);
      end
      for (int k = 0; k < wr_cyc.size() && k < lens[t] - 2; k++) begin
        n_assert++;
        if (wr_cyc[k] !== 8 + k || wr_addr[k] !== k || wr_data[k] !== ref_win(k)) begin
          n_fail++;
          $display("FAIL b2b job%0d write%0d: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                   t, k, wr_cyc[k], wr_addr[k], wr_data[k], 8 + k, k, ref_win(k));
        end
      end
      n_assert++;
      if (clear_cyc.size() != 1 || clear_cyc[0] != 1 || done_cyc.size() != 1 || done_cyc[0] != lens[t] + 6) begin
        n_fail++;
        $display("FAIL b2b job%0d clear/done: got %0d clears %0d dones, expected clear at 1 and done at %0d",
                 t, clear_cyc.size(), done_cyc.size(), lens[t] + 6);
      end
    end
  endtask

  task automatic test_random();
    int l;
    for (int it = 0; it < 4; it++) begin
      l = int'($urandom_range(3, 24));
      randomize_mem(l);
      clear_logs();
      start_job(l);
      wait_done(80);
      repeat (3) @(posedge clk);
      n_assert++;
      if (wr_cyc.size() != l - 2 || done_cyc.size() != 1 || done_cyc[0] != l + 6) begin
        n_fail++;
        $display("FAIL rand%0d len%0d: got %0d writes %0d dones, expected %0d writes and done at %0d",
                 it, l, wr_cyc.size(), done_cyc.size(), l - 2, l + 6);
      end
      for (int k = 0; k < wr_cyc.size() && k < l - 2; k++) begin
        n_assert++;
        if (wr_cyc[k] !== 8 + k || wr_addr[k] !== k || wr_data[k] !== ref_win(k)) begin
          n_fail++;
          $display("FAIL rand%0d write%0d: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                   it, k, wr_cyc[k], wr_addr[k], wr_data[k], 8 + k, k, ref_win(k));
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = '0;
      fmem[i] = '0;
    end
    test_reset();
    test_patterns();
    test_short_len();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer that feeds the 3-tap Conv stage and captures its output.
- On start, reads 3 weights from weight memory and streams len features from feature memory into Conv. For each full 3-sample window it writes Conv's result to output memory.
- Sits between the on-chip weight/feature/output SRAMs and the Conv datapath.

Parameters:
DATA_BITS, 8, width of weight and feature samples (matches `DATA_BITS)
ADDR_BITS, 10, address width of all three memories
RES_BITS, 2*DATA_BITS+2, width of Conv result and output word

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle job request, sampled in IDLE only
len  input  ADDR_BITS  feature count, sampled with start
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse at job end
w_addr  output  ADDR_BITS  weight memory read address
w_rdata  input  DATA_BITS  weight memory data, 1-cycle sync read latency
if_addr  output  ADDR_BITS  feature memory read address
if_rdata  input  DATA_BITS  feature memory data, 1-cycle sync read latency
conv_clear  output  1  Conv clear
conv_w_w  output  1  Conv weight shift enable
conv_w_in  output  DATA_BITS  Conv weight data
conv_if_w  output  1  Conv feature shift enable
conv_if_in  output  DATA_BITS  Conv feature data
conv_result  input  RES_BITS  Conv signed result
out_we  output  1  output memory write enable
out_addr  output  ADDR_BITS  output memory write address
out_wdata  output  RES_BITS  output memory write data

Behaviour:
- Conv contract: clear empties both shift registers synchronously. w_w and if_w each shift one sample in per edge. conv_result is combinational from register contents, valid the cycle after an if_w edge. Window result = w[0]*f[i-2] + w[1]*f[i-1] + w[2]*f[i], where w[0] is the first weight pushed.
- Reset (async, any state): state IDLE. All outputs 0, counters 0.
- FSM states: IDLE, CLEAR, LOAD_W, LOAD_F, FINISH.
- Timeline (cycle 0 = edge where start sampled, len>=3):
  - Cycle 1 (CLEAR): conv_clear=1, w_addr=0.
  - Cycles 2..4 (LOAD_W): conv_w_w=1, conv_w_in=w_rdata (weights 0,1,2 in order). w_addr=1,2 in cycles 2,3. if_addr=0 in cycle 4.
  - Cycles 5..4+len (LOAD_F): conv_if_w=1, conv_if_in=if_rdata of feature i at cycle 5+i. if_addr=i+1 in the same cycle while i+1<len.
  - For i>=2, at cycle 6+i: out_we=1, out_addr=i-2, out_wdata=conv_result. This gives len-2 writes, consecutive, cycles 8..5+len.
  - Cycle 6+len (FINISH): done=1, busy=0. Back to IDLE next cycle.
- busy=1 in cycles 1..5+len.
- len<3: start goes IDLE→FINISH. done=1 at cycle 1. No memory reads, no Conv strobes, no writes.
- start while not IDLE is ignored. len is latched; later changes have no effect.
- A new start may be sampled in the cycle after done.
- out_wdata is passed through unmodified: signed, RES_BITS, no saturation.
- Output and strobe signals are registered, except where they are assigned from w_rdata, if_rdata or conv_result in the stated cycle.
- Address outputs hold their last value when not in use; memories ignore them.
- Max len = 2^ADDR_BITS-1. Counters must not wrap within a job.

Test Plan:
- Weights 1,2,3, features 1,2,3,4,5, len=5 → out_we at cycles 8,9,10 with addr 0,1,2 and data 14,20,26. done at cycle 11. busy high cycles 1..10.
- Weights -1,0,1 (DATA_BITS=8), features 10,-20,30,-40, len=4 → writes addr 0 = 20, addr 1 = -20 (0x3FFEC). No other out_we pulses.
- len=2 and len=0 → done at cycle 1. conv_clear, conv_w_w, conv_if_w and out_we stay 0. busy never high.
- start pulsed again at cycles 3 and 7 during a len=5 job → ignored. Exactly 3 writes. Single done.
- rst asserted mid-LOAD_F (cycle 6) → all outputs 0 immediately, no further writes. Fresh start with len=3 gives one write at cycle 8.
- Back-to-back jobs (start in cycle after done) with len=3 then len=6 → 1 then 4 writes with correct addresses and values. conv_clear asserted at the start of each job.
